// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared arbiter state and memory write-type encodings
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_t;

  // Also the controller's memwrite encoding.
  localparam logic [1:0] WT_LOAD = 2'b00;
  localparam logic [1:0] WT_D    = 2'b01;
  localparam logic [1:0] WT_W    = 2'b10;
  localparam logic [1:0] WT_B    = 2'b11;

  // IF takes the slot when DM is absent, or when IF has been starved.
  function automatic logic if_wins(input logic if_cand, input logic dm_cand, input logic starved);
    return if_cand & (~dm_cand | starved);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester, memory-port and status signals of the arbiter
interface mem_port_arbiter_if #(
  parameter int N = 64,
  parameter int W = 32
);
  logic         if_req;
  logic [W-1:0] if_addr;
  logic [W-1:0] if_rdata;
  logic         if_valid;

  logic         dm_req;
  logic [1:0]   dm_wtype;
  logic [N-1:0] dm_addr;
  logic [N-1:0] dm_wdata;
  logic [N-1:0] dm_rdata;
  logic         dm_valid;

  logic         mem_req;
  logic [1:0]   mem_wtype;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic [N-1:0] mem_rdata;
  logic         mem_ready;

  logic         stall_if;
  logic         stall_mem;
  logic         timeout_err;

  modport slave (
    input  if_req, if_addr, dm_req, dm_wtype, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_rdata, if_valid, dm_rdata, dm_valid, mem_req, mem_wtype, mem_addr, mem_wdata,
           stall_if, stall_mem, timeout_err
  );

  modport master (
    output if_req, if_addr, dm_req, dm_wtype, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_valid, dm_rdata, dm_valid, mem_req, mem_wtype, mem_addr, mem_wdata,
           stall_if, stall_mem, timeout_err
  );
endinterface

// File: rtl/arb_timer.sv
// rtl/arb_timer.sv - saturating event counter with clear/enable; o_term while count == LIMIT
module arb_timer #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term
);
  localparam int WIDTH = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [WIDTH-1:0] TERM = WIDTH'(LIMIT);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != TERM)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_term = (r_count == TERM);
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and data memory
// Serialises accesses, returns read data to the issuer, raises stalls and a sticky timeout error.
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int N            = 64,
  parameter int W            = 32,
  parameter int TIMEOUT      = 16,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam bit TIMEOUT_EN = (TIMEOUT > 0);
  // The wait timer flags the cycle that would be the TIMEOUT-th consecutive wait.
  localparam int WAIT_LAST  = TIMEOUT_EN ? TIMEOUT - 1 : 0;

  arb_state_t   r_state;
  logic         r_mem_req;
  logic [1:0]   r_mem_wtype;
  logic [N-1:0] r_mem_addr;
  logic [N-1:0] r_mem_wdata;
  logic [W-1:0] r_if_rdata;
  logic [N-1:0] r_dm_rdata;
  logic         r_if_valid;
  logic         r_dm_valid;
  logic         r_timeout_err;

  logic w_if_elig, w_dm_elig, w_if_cand, w_dm_cand;
  logic w_busy, w_done, w_arb, w_timeout, w_wait_last, w_starved;
  logic w_grant_if, w_grant_dm, w_grant;

  assign w_if_elig  = bus.if_req & ~r_if_valid;
  assign w_dm_elig  = bus.dm_req & ~r_dm_valid;
  assign w_busy     = (r_state != IDLE);
  assign w_done     = w_busy & bus.mem_ready;
  assign w_timeout  = TIMEOUT_EN & w_busy & ~bus.mem_ready & w_wait_last;
  assign w_arb      = ~w_busy | w_done;
  assign w_if_cand  = w_if_elig & (r_state != BUSY_IF);
  assign w_dm_cand  = w_dm_elig & (r_state != BUSY_DM);
  assign w_grant_if = w_arb & if_wins(w_if_cand, w_dm_cand, w_starved);
  assign w_grant_dm = w_arb & w_dm_cand & ~w_grant_if;
  assign w_grant    = w_grant_if | w_grant_dm;

  arb_timer #(.LIMIT(WAIT_LAST)) u_wait_timer (
    .clk    (clk),
    .rst    (reset),
    .i_clr  (w_grant),
    .i_en   (w_busy & ~bus.mem_ready),
    .o_term (w_wait_last)
  );

  arb_timer #(.LIMIT(STARVE_LIMIT)) u_starve_timer (
    .clk    (clk),
    .rst    (reset),
    .i_clr  (w_grant_if),
    .i_en   (w_grant_dm & w_if_cand),
    .o_term (w_starved)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_mem_req     <= 1'b0;
      r_mem_wtype   <= WT_LOAD;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_if_rdata    <= '0;
      r_dm_rdata    <= '0;
      r_if_valid    <= 1'b0;
      r_dm_valid    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_dm_valid <= 1'b0;
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
        r_mem_req     <= 1'b0;
        r_state       <= IDLE;
        if (r_state == BUSY_IF) begin
          r_if_valid <= 1'b1;
          r_if_rdata <= '1;
        end else begin
          r_dm_valid <= 1'b1;
          r_dm_rdata <= '1;
        end
      end else begin
        if (w_done) begin
          r_mem_req <= 1'b0;
          r_state   <= IDLE;
          if (r_state == BUSY_IF) begin
            r_if_valid <= 1'b1;
            r_if_rdata <= bus.mem_rdata[W-1:0];
          end else begin
            r_dm_valid <= 1'b1;
            if (r_mem_wtype == WT_LOAD) r_dm_rdata <= bus.mem_rdata;
          end
        end
        // A grant in a completion cycle overrides the drop above: back-to-back reload.
        if (w_grant_if) begin
          r_state     <= BUSY_IF;
          r_mem_req   <= 1'b1;
          r_mem_wtype <= WT_LOAD;
          r_mem_addr  <= {{(N-W){1'b0}}, bus.if_addr};
          r_mem_wdata <= '0;
        end else if (w_grant_dm) begin
          r_state     <= BUSY_DM;
          r_mem_req   <= 1'b1;
          r_mem_wtype <= bus.dm_wtype;
          r_mem_addr  <= bus.dm_addr;
          r_mem_wdata <= bus.dm_wdata;
        end
      end
    end
  end

  assign bus.mem_req     = r_mem_req;
  assign bus.mem_wtype   = r_mem_wtype;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.if_rdata    = r_if_rdata;
  assign bus.if_valid    = r_if_valid;
  assign bus.dm_rdata    = r_dm_rdata;
  assign bus.dm_valid    = r_dm_valid;
  assign bus.timeout_err = r_timeout_err;
  assign bus.stall_if    = w_if_elig;
  assign bus.stall_mem   = w_dm_elig;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  import mips_pkg::*;

  localparam int N            = 64;
  localparam int W            = 32;
  localparam int TIMEOUT      = 16;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int passed = 0;
  logic [N-1:0] exp_dm_rdata;

  mem_port_arbiter_if #(.N(N), .W(W)) bus ();

  mem_port_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] mem_fn(input logic [N-1:0] a);
    return {a[63:32] + 32'h1357_9BDF, a[31:0] ^ 32'hC3A5_5A3C};
  endfunction

  always_comb bus.mem_rdata = mem_fn(bus.mem_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.dm_req    = 1'b0;
    bus.dm_wtype  = WT_LOAD;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.mem_ready = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_dm_rdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b0) $display("FAIL reset_mem_req got=%0h exp=0", bus.mem_req); else passed++;
    checks++; if (bus.mem_wtype !== 2'b00) $display("FAIL reset_mem_wtype got=%0h exp=0", bus.mem_wtype); else passed++;
    checks++; if (bus.mem_addr !== 64'h0) $display("FAIL reset_mem_addr got=%0h exp=0", bus.mem_addr); else passed++;
    checks++; if (bus.mem_wdata !== 64'h0) $display("FAIL reset_mem_wdata got=%0h exp=0", bus.mem_wdata); else passed++;
    checks++; if (bus.if_valid !== 1'b0 || bus.dm_valid !== 1'b0) $display("FAIL reset_valids got=%0b%0b exp=00", bus.if_valid, bus.dm_valid); else passed++;
    checks++; if (bus.if_rdata !== 32'h0) $display("FAIL reset_if_rdata got=%0h exp=0", bus.if_rdata); else passed++;
    checks++; if (bus.dm_rdata !== 64'h0) $display("FAIL reset_dm_rdata got=%0h exp=0", bus.dm_rdata); else passed++;
    checks++; if (bus.timeout_err !== 1'b0) $display("FAIL reset_timeout_err got=%0h exp=0", bus.timeout_err); else passed++;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_dm_rdata = '0;
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b0 || bus.stall_if !== 1'b0) $display("FAIL reset_idle got=%0b%0b exp=00", bus.mem_req, bus.stall_if); else passed++;
    step();
  endtask

  task automatic test_if_fetch();
    logic [N-1:0] m;
    m = mem_fn(64'h40);
    bus.mem_ready = 1'b1;
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h40;
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b0 || bus.stall_if !== 1'b1) $display("FAIL fetch_c0 got req=%0b stall=%0b exp req=0 stall=1", bus.mem_req, bus.stall_if); else passed++;
    step();
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 64'h40 || bus.mem_wtype !== WT_LOAD)
      $display("FAIL fetch_c1 got req=%0b addr=%0h wt=%0h exp req=1 addr=40 wt=0", bus.mem_req, bus.mem_addr, bus.mem_wtype); else passed++;
    step();
    @(negedge clk);
    checks++; if (bus.if_valid !== 1'b1 || bus.if_rdata !== m[31:0] || bus.stall_if !== 1'b0)
      $display("FAIL fetch_c2 got v=%0b d=%0h stall=%0b exp v=1 d=%0h stall=0", bus.if_valid, bus.if_rdata, bus.stall_if, m[31:0]); else passed++;
    step();
    bus.if_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.if_valid !== 1'b0 || bus.mem_req !== 1'b0) $display("FAIL fetch_c3 got v=%0b req=%0b exp 0 0", bus.if_valid, bus.mem_req); else passed++;
    step();
  endtask

  task automatic test_tie();
    logic [N-1:0] m;
    m = mem_fn(64'h80);
    bus.mem_ready = 1'b1;
    bus.if_req = 1'b1;  bus.if_addr = 32'h80;
    bus.dm_req = 1'b1;  bus.dm_wtype = WT_D; bus.dm_addr = 64'h100; bus.dm_wdata = 64'h1111_2222_3333_4444;
    @(negedge clk);
    checks++; if (bus.stall_if !== 1'b1 || bus.stall_mem !== 1'b1) $display("FAIL tie_c0_stall got %0b%0b exp 11", bus.stall_if, bus.stall_mem); else passed++;
    step();
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 64'h100 || bus.mem_wtype !== WT_D || bus.mem_wdata !== 64'h1111_2222_3333_4444 || bus.stall_if !== 1'b1)
      $display("FAIL tie_c1_dm got req=%0b addr=%0h wt=%0h wd=%0h stall_if=%0b", bus.mem_req, bus.mem_addr, bus.mem_wtype, bus.mem_wdata, bus.stall_if); else passed++;
    step();
    @(negedge clk);
    checks++; if (bus.dm_valid !== 1'b1 || bus.mem_req !== 1'b1 || bus.mem_addr !== 64'h80 || bus.mem_wtype !== WT_LOAD || bus.stall_if !== 1'b1 || bus.stall_mem !== 1'b0)
      $display("FAIL tie_c2_b2b got dv=%0b req=%0b addr=%0h wt=%0h stall=%0b%0b exp 1 1 80 0 10", bus.dm_valid, bus.mem_req, bus.mem_addr, bus.mem_wtype, bus.stall_if, bus.stall_mem); else passed++;
    step();
    bus.dm_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.if_valid !== 1'b1 || bus.dm_valid !== 1'b0 || bus.if_rdata !== m[31:0] || bus.dm_rdata !== exp_dm_rdata)
      $display("FAIL tie_c3_if got iv=%0b dv=%0b d=%0h dmd=%0h exp 1 0 %0h %0h", bus.if_valid, bus.dm_valid, bus.if_rdata, bus.dm_rdata, m[31:0], exp_dm_rdata); else passed++;
    step();
    bus.if_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b0) $display("FAIL tie_c4_idle got req=%0b exp 0", bus.mem_req); else passed++;
    step();
  endtask

  // IF is flushed after each lost tie so that every round is a fresh tie in IDLE.
  task automatic test_starvation();
    int lost;
    logic if_first;
    logic [W-1:0] ia;
    logic [N-1:0] da;
    lost = 0;
    bus.mem_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      if_first = (lost >= STARVE_LIMIT);
      ia = 32'h1000 + 32'(r * 16);
      da = 64'h2000 + 64'(r * 8);
      bus.if_req = 1'b1; bus.if_addr = ia;
      bus.dm_req = 1'b1; bus.dm_wtype = WT_LOAD; bus.dm_addr = da;
      step();
      if (!if_first) bus.if_req = 1'b0;
      @(negedge clk);
      checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== (if_first ? {32'h0, ia} : da))
        $display("FAIL starve_round%0d_winner got req=%0b addr=%0h exp addr=%0h", r, bus.mem_req, bus.mem_addr, if_first ? {32'h0, ia} : da); else passed++;
      if (if_first) begin
        lost = 0;
        step();
        bus.if_req = 1'b0;
        @(negedge clk);
        checks++; if (bus.if_valid !== 1'b1 || bus.mem_addr !== da) $display("FAIL starve_round%0d_b2b got iv=%0b addr=%0h exp 1 %0h", r, bus.if_valid, bus.mem_addr, da); else passed++;
        step();
      end else begin
        lost++;
        step();
      end
      bus.dm_req = 1'b0;
      exp_dm_rdata = mem_fn(da);
      @(negedge clk);
      checks++; if (bus.dm_valid !== 1'b1 || bus.dm_rdata !== exp_dm_rdata) $display("FAIL starve_round%0d_dm got v=%0b d=%0h exp 1 %0h", r, bus.dm_valid, bus.dm_rdata, exp_dm_rdata); else passed++;
      step();
      @(negedge clk);
      checks++; if (bus.mem_req !== 1'b0) $display("FAIL starve_round%0d_idle got req=%0b exp 0", r, bus.mem_req); else passed++;
      step();
    end
  endtask

  task automatic test_store();
    int pulses;
    bus.mem_ready = 1'b1;
    bus.dm_req = 1'b1; bus.dm_wtype = WT_LOAD; bus.dm_addr = 64'h3000;
    step(); step();
    bus.dm_req = 1'b0;
    exp_dm_rdata = mem_fn(64'h3000);
    @(negedge clk);
    checks++; if (bus.dm_valid !== 1'b1 || bus.dm_rdata !== exp_dm_rdata) $display("FAIL store_preload got v=%0b d=%0h exp 1 %0h", bus.dm_valid, bus.dm_rdata, exp_dm_rdata); else passed++;
    step();
    bus.dm_req = 1'b1; bus.dm_wtype = WT_W; bus.dm_addr = 64'h3008; bus.dm_wdata = 64'hDEAD_BEEF_0123_4567;
    step();
    @(negedge clk);
    checks++; if (bus.mem_wtype !== WT_W || bus.mem_wdata !== 64'hDEAD_BEEF_0123_4567 || bus.mem_addr !== 64'h3008)
      $display("FAIL store_bus got wt=%0h wd=%0h addr=%0h exp 2 deadbeef01234567 3008", bus.mem_wtype, bus.mem_wdata, bus.mem_addr); else passed++;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      @(negedge clk);
      if (bus.dm_valid === 1'b1) begin
        pulses++;
        bus.dm_req = 1'b0;
        checks++; if (bus.dm_rdata !== exp_dm_rdata) $display("FAIL store_rdata_kept got=%0h exp=%0h", bus.dm_rdata, exp_dm_rdata); else passed++;
      end
    end
    checks++; if (pulses != 1) $display("FAIL store_pulses got=%0d exp=1", pulses); else passed++;
    step();
  endtask

  task automatic test_random();
    logic if_pend, dm_pend, if_seen, dm_seen, ok;
    logic [W-1:0] ia;
    logic [N-1:0] da, dw, m;
    logic [1:0] dt;
    int waits, acc, done;
    if_pend = 0; dm_pend = 0; if_seen = 0; dm_seen = 0;
    ia = '0; da = '0; dw = '0; dt = WT_LOAD;
    waits = 0; acc = 0; done = 0;
    for (int cyc = 0; cyc < 900; cyc++) begin
      if (if_seen) begin if_pend = 0; if_seen = 0; bus.if_req = 1'b0; end
      if (dm_seen) begin dm_pend = 0; dm_seen = 0; bus.dm_req = 1'b0; end
      if (cyc >= 700 && !if_pend && !dm_pend) break;
      if (cyc < 700 && !if_pend && $urandom_range(0, 2) == 0) begin
        ia = $urandom & 32'hFFFF_FFFC;
        if_pend = 1; bus.if_req = 1'b1; bus.if_addr = ia;
      end
      if (cyc < 700 && !dm_pend && $urandom_range(0, 2) == 0) begin
        dt = 2'($urandom_range(0, 3));
        da = {32'($urandom), 32'($urandom)};
        dw = {32'($urandom), 32'($urandom)};
        dm_pend = 1; bus.dm_req = 1'b1; bus.dm_wtype = dt; bus.dm_addr = da; bus.dm_wdata = dw;
      end
      bus.mem_ready = (waits >= 5) || ($urandom_range(0, 9) < 6);
      @(negedge clk);
      if (bus.mem_req === 1'b1 && bus.mem_ready) begin
        acc++; waits = 0;
        ok = (if_pend && !if_seen && bus.mem_addr === {32'h0, ia} && bus.mem_wtype === WT_LOAD) ||
             (dm_pend && !dm_seen && bus.mem_addr === da && bus.mem_wtype === dt && (dt == WT_LOAD || bus.mem_wdata === dw));
        checks++; if (!ok) $display("FAIL rand_access cyc=%0d got addr=%0h wt=%0h wd=%0h", cyc, bus.mem_addr, bus.mem_wtype, bus.mem_wdata); else passed++;
      end else if (bus.mem_req === 1'b1) begin
        waits++;
      end
      if (bus.if_valid === 1'b1) begin
        done++; m = mem_fn({32'h0, ia});
        checks++; if (!if_pend || bus.if_rdata !== m[31:0]) $display("FAIL rand_if cyc=%0d pend=%0b got=%0h exp=%0h", cyc, if_pend, bus.if_rdata, m[31:0]); else passed++;
        if_seen = 1;
      end
      if (bus.dm_valid === 1'b1) begin
        done++;
        if (dt == WT_LOAD) exp_dm_rdata = mem_fn(da);
        checks++; if (!dm_pend || bus.dm_rdata !== exp_dm_rdata) $display("FAIL rand_dm cyc=%0d pend=%0b wt=%0h got=%0h exp=%0h", cyc, dm_pend, dt, bus.dm_rdata, exp_dm_rdata); else passed++;
        dm_seen = 1;
      end
      step();
    end
    checks++; if (if_pend || dm_pend) $display("FAIL rand_drain got pending if=%0b dm=%0b exp none", if_pend, dm_pend); else passed++;
    checks++; if (acc != done || bus.timeout_err !== 1'b0) $display("FAIL rand_count got acc=%0d done=%0d terr=%0b exp equal 0", acc, done, bus.timeout_err); else passed++;
    idle_inputs();
    step(); step();
  endtask

  task automatic test_timeout();
    int hi, vcyc;
    logic [N-1:0] vdata;
    logic [N-1:0] m;
    hi = 0; vcyc = -1; vdata = '0;
    bus.mem_ready = 1'b0;
    bus.dm_req = 1'b1; bus.dm_wtype = WT_LOAD; bus.dm_addr = 64'h5000;
    step();
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) hi++;
      if (bus.dm_valid === 1'b1) begin
        vcyc = c; vdata = bus.dm_rdata;
        break;
      end
      step();
    end
    checks++; if (hi != TIMEOUT) $display("FAIL timeout_req_cycles got=%0d exp=%0d", hi, TIMEOUT); else passed++;
    checks++; if (vcyc != TIMEOUT + 1 || vdata !== {N{1'b1}}) $display("FAIL timeout_valid got cyc=%0d d=%0h exp cyc=%0d all ones", vcyc, vdata, TIMEOUT + 1); else passed++;
    checks++; if (bus.timeout_err !== 1'b1) $display("FAIL timeout_err_set got=%0b exp=1", bus.timeout_err); else passed++;
    step();
    bus.dm_req = 1'b0;
    bus.mem_ready = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'h7000;
    m = mem_fn(64'h7000);
    step(); step();
    bus.if_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.if_valid !== 1'b1 || bus.if_rdata !== m[31:0] || bus.timeout_err !== 1'b1)
      $display("FAIL timeout_sticky got v=%0b d=%0h terr=%0b exp 1 %0h 1", bus.if_valid, bus.if_rdata, bus.timeout_err, m[31:0]); else passed++;
    step();
    do_reset();
    @(negedge clk);
    checks++; if (bus.timeout_err !== 1'b0) $display("FAIL timeout_err_cleared got=%0b exp=0", bus.timeout_err); else passed++;
    step();
  endtask

  task automatic test_reset_mid_busy();
    int pulses, reqs;
    logic [N-1:0] m;
    bus.mem_ready = 1'b0;
    bus.dm_req = 1'b1; bus.dm_wtype = WT_LOAD; bus.dm_addr = 64'h6000;
    step(); step();
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.mem_req !== 1'b0 || bus.dm_valid !== 1'b0) $display("FAIL async_reset got req=%0b dv=%0b exp 0 0", bus.mem_req, bus.dm_valid); else passed++;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    pulses = 0; reqs = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.dm_valid === 1'b1) pulses++;
      if (bus.mem_req === 1'b1) reqs++;
      step();
    end
    checks++; if (pulses != 0 || reqs != 0) $display("FAIL abandoned_access got pulses=%0d reqs=%0d exp 0 0", pulses, reqs); else passed++;
    bus.if_req = 1'b1; bus.if_addr = 32'h44;
    m = mem_fn(64'h44);
    step();
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 64'h44) $display("FAIL post_reset_grant got req=%0b addr=%0h exp 1 44", bus.mem_req, bus.mem_addr); else passed++;
    step();
    bus.if_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.if_valid !== 1'b1 || bus.if_rdata !== m[31:0]) $display("FAIL post_reset_fetch got v=%0b d=%0h exp 1 %0h", bus.if_valid, bus.if_rdata, m[31:0]); else passed++;
    step();
  endtask

  initial begin
    test_reset();
    test_if_fetch();
    test_tie();
    test_starvation();
    test_store();
    test_random();
    test_timeout();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
